// File: rtl/instruction_fetch_if.sv
// IF-stage control/debug inputs and IF/ID pipeline outputs.
// The slave side is the fetch stage; the master side drives it.
interface instruction_fetch_if #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 8
) ();
    logic               i_enable;
    logic               i_stall;
    logic               i_redirect;
    logic [NB_DATA-1:0] i_redirect_addr;
    logic               i_load_en;
    logic [NB_ADDR-1:0] i_load_addr;
    logic [NB_DATA-1:0] i_load_data;
    logic [NB_DATA-1:0] o_instruction;
    logic [NB_DATA-1:0] o_pcounter4;
    logic [NB_DATA-1:0] o_pc;
    logic               o_valid;
    logic               o_halt;

    modport slave (
        input  i_enable, i_stall, i_redirect, i_redirect_addr,
        input  i_load_en, i_load_addr, i_load_data,
        output o_instruction, o_pcounter4, o_pc, o_valid, o_halt
    );

    modport master (
        output i_enable, i_stall, i_redirect, i_redirect_addr,
        output i_load_en, i_load_addr, i_load_data,
        input  o_instruction, o_pcounter4, o_pc, o_valid, o_halt
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, debug-loadable instruction memory and registered IF/ID outputs.
// Handles hazard stall, ID redirect and HALT-word detection.
module instruction_fetch #(
    parameter int unsigned        NB_DATA   = 32,
    parameter int unsigned        NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [NB_DATA-1:0] NOP_WORD  = 32'h0000_0000
) (
    input logic                clk,
    input logic                i_rst,
    instruction_fetch_if.slave bus
);
    localparam int unsigned MEM_DEPTH = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem [MEM_DEPTH];

    logic [NB_DATA-1:0] pc_q,    pc_next;
    logic [NB_DATA-1:0] instr_q, instr_next;
    logic [NB_DATA-1:0] pc4_q,   pc4_next;
    logic [NB_DATA-1:0] opc_q,   opc_next;
    logic               valid_q, valid_next;
    logic               halt_q,  halt_next;

    logic [NB_ADDR-1:0] fetch_idx;
    logic [NB_DATA-1:0] fetch_word;
    logic [NB_DATA-1:0] pc_plus4;
    logic               frozen;

    // Upper PC bits alias onto the same words.
    assign fetch_idx  = pc_q[NB_ADDR+1:2];
    assign fetch_word = mem[fetch_idx];
    assign pc_plus4   = pc_q + NB_DATA'(4);
    assign frozen     = bus.i_load_en || !bus.i_enable;

    // Debug writes are dropped while reset is asserted; contents survive reset.
    always_ff @(posedge clk) begin
        if (!i_rst && bus.i_load_en) begin
            mem[bus.i_load_addr] <= bus.i_load_data;
        end
    end

    // Next-state selection: redirect > stall > halted > advance.
    always_comb begin
        pc_next    = pc_q;
        instr_next = instr_q;
        pc4_next   = pc4_q;
        opc_next   = opc_q;
        valid_next = valid_q;
        halt_next  = halt_q;
        if (!frozen) begin
            if (bus.i_redirect) begin
                pc_next    = bus.i_redirect_addr & ~NB_DATA'(3);
                instr_next = NOP_WORD;
                valid_next = 1'b0;
                halt_next  = 1'b0;
            end else if (bus.i_stall) begin
                pc_next = pc_q;
            end else if (halt_q) begin
                instr_next = NOP_WORD;
                valid_next = 1'b0;
            end else begin
                instr_next = fetch_word;
                opc_next   = pc_q;
                pc4_next   = pc_plus4;
                valid_next = 1'b1;
                if (fetch_word == HALT_WORD) begin
                    halt_next = 1'b1;
                end else begin
                    pc_next = pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            opc_q   <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            instr_q <= instr_next;
            pc4_q   <= pc4_next;
            opc_q   <= opc_next;
            valid_q <= valid_next;
            halt_q  <= halt_next;
        end
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_pcounter4   = pc4_q;
    assign bus.o_pc          = opc_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_halt        = halt_q;
endmodule
